// File: rtl/anton_neopixel_sequencer_if.sv
// Register/stream bundle between the control registers, the sequencer and
// the NeoPixel stream datapath. master = register side, slave = sequencer.
`ifndef ANTON_SEQ_DEFINES
`define ANTON_SEQ_DEFINES
`define BUFFER_END_DEFAULT 12
`define CLOG2(x) $clog2(x)
`define ENUM_STATE_RESET 1'b0
`define ENUM_STATE_TRANSMIT 1'b1
`endif

interface anton_neopixel_sequencer_if #(
    parameter int BUFFER_BITS = `CLOG2(`BUFFER_END_DEFAULT + 1)
);
    logic                   regCtrlRun;
    logic                   regCtrlLoop;
    logic                   regCtrl32bit;
    logic [BUFFER_BITS-1:0] regPixelEnd;
    logic                   state;
    logic [BUFFER_BITS-1:0] pixelIndex;
    logic [2:0]             pixelBitIndex;
    logic [1:0]             channelIndex;
    logic [2:0]             bitPatternIndex;
    logic                   streamSyncOf;
    logic                   busy;

    modport master (
        output regCtrlRun, regCtrlLoop, regCtrl32bit, regPixelEnd,
        input  state, pixelIndex, pixelBitIndex, channelIndex,
               bitPatternIndex, streamSyncOf, busy
    );

    modport slave (
        input  regCtrlRun, regCtrlLoop, regCtrl32bit, regPixelEnd,
        output state, pixelIndex, pixelBitIndex, channelIndex,
               bitPatternIndex, streamSyncOf, busy
    );
endinterface

// File: rtl/anton_neopixel_sequencer.sv
// NeoPixel frame sequencer: walks pixel/channel/bit/pattern-slot indices one
// slot per clock, then holds the line low for the latch gap.
// Optional feature macro: ANTON_SEQ_SHADOW_CFG_EN (frame-start capture of
// mode, end index and loop; default build uses live register values).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a rising edge of regCtrlRun
// TRANSMIT | streaming pattern slots, indices advance every clock
// GAP      | latch gap, RESET_CYCLES clocks, sync pulse on the last one
`ifndef ANTON_SEQ_DEFINES
`define ANTON_SEQ_DEFINES
`define BUFFER_END_DEFAULT 12
`define CLOG2(x) $clog2(x)
`define ENUM_STATE_RESET 1'b0
`define ENUM_STATE_TRANSMIT 1'b1
`endif

module anton_neopixel_sequencer #(
    parameter int BUFFER_END   = `BUFFER_END_DEFAULT,
    parameter int RESET_CYCLES = 400
) (
    input  logic                           clk7mhz,
    input  logic                           syncReset,
    anton_neopixel_sequencer_if.slave      bus
);
    localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1);
    localparam int HI_BITS     = BUFFER_BITS - 2;
    localparam logic [BUFFER_BITS-1:0] END_IDX  = BUFFER_BITS'(BUFFER_END);
    localparam logic [15:0]            GAP_LAST = 16'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, TRANSMIT, GAP} fsm_t;

    fsm_t                   fsm;
    logic [15:0]            gap_cnt;
    logic                   run_prev;
    logic [BUFFER_BITS-1:0] pix_idx;
    logic [2:0]             bit_idx;
    logic [1:0]             ch_idx;
    logic [2:0]             pat_idx;
    logic                   sync_of;
    logic                   busy_q;
    logic                   state_q;

    logic                   cfg_32bit;
    logic                   cfg_loop;
    logic [BUFFER_BITS-1:0] cfg_end;
    logic [BUFFER_BITS-1:0] eff_end;
    logic [HI_BITS-1:0]     pix_hi_next;
    logic [BUFFER_BITS-1:0] pix_next;
    logic                   is_last;
    logic                   start_idle;
    logic                   restart;

    assign start_idle = (fsm == IDLE) && bus.regCtrlRun && !run_prev;
    assign restart    = (fsm == GAP) && (gap_cnt == GAP_LAST) && bus.regCtrlRun && cfg_loop;

`ifdef ANTON_SEQ_SHADOW_CFG_EN
    logic                   shd_32bit;
    logic                   shd_loop;
    logic [BUFFER_BITS-1:0] shd_end;

    // Snapshot the frame configuration on every entry into TRANSMIT
    always_ff @(posedge clk7mhz) begin
        if (!syncReset) begin
            shd_32bit <= 1'b0;
            shd_loop  <= 1'b0;
            shd_end   <= '0;
        end else if (start_idle || restart) begin
            shd_32bit <= bus.regCtrl32bit;
            shd_loop  <= bus.regCtrlLoop;
            shd_end   <= bus.regPixelEnd;
        end
    end

    assign cfg_32bit = shd_32bit;
    assign cfg_loop  = shd_loop;
    assign cfg_end   = shd_end;
`else
    assign cfg_32bit = bus.regCtrl32bit;
    assign cfg_loop  = bus.regCtrlLoop;
    assign cfg_end   = bus.regPixelEnd;
`endif

    // The end index is clamped to the buffer so the step add never overruns it
    assign eff_end     = (cfg_end > END_IDX) ? END_IDX : cfg_end;
    assign pix_hi_next = pix_idx[BUFFER_BITS-1:2] + HI_BITS'(1);
    assign pix_next    = cfg_32bit ? {pix_hi_next, 2'b00} : pix_idx + BUFFER_BITS'(1);
    assign is_last     = cfg_32bit ? (pix_idx[BUFFER_BITS-1:2] >= eff_end[BUFFER_BITS-1:2])
                                   : (pix_idx >= eff_end);

    // Frame FSM, index counters and gap timer with registered outputs
    always_ff @(posedge clk7mhz) begin
        if (!syncReset) begin
            fsm      <= IDLE;
            gap_cnt  <= '0;
            run_prev <= 1'b0;
            pix_idx  <= '0;
            bit_idx  <= '0;
            ch_idx   <= '0;
            pat_idx  <= '0;
            sync_of  <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= `ENUM_STATE_RESET;
        end else begin
            run_prev <= bus.regCtrlRun;
            sync_of  <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start_idle) begin
                        fsm     <= TRANSMIT;
                        state_q <= `ENUM_STATE_TRANSMIT;
                        busy_q  <= 1'b1;
                    end
                end
                TRANSMIT: begin
                    if (!bus.regCtrlRun) begin
                        // abort: latch whatever has been sent so far
                        fsm     <= GAP;
                        state_q <= `ENUM_STATE_RESET;
                        gap_cnt <= '0;
                        pix_idx <= '0;
                        bit_idx <= '0;
                        ch_idx  <= '0;
                        pat_idx <= '0;
                    end else begin
                        pat_idx <= pat_idx + 3'd1;
                        if (cfg_32bit) pix_idx[1:0] <= 2'b00;
                        if (pat_idx == 3'd7) begin
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                if (ch_idx == 2'd2) begin
                                    ch_idx <= 2'd0;
                                    if (is_last) begin
                                        fsm     <= GAP;
                                        state_q <= `ENUM_STATE_RESET;
                                        gap_cnt <= '0;
                                        pix_idx <= '0;
                                    end else begin
                                        pix_idx <= pix_next;
                                    end
                                end else begin
                                    ch_idx <= ch_idx + 2'd1;
                                end
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (restart) begin
                            fsm     <= TRANSMIT;
                            state_q <= `ENUM_STATE_TRANSMIT;
                        end else begin
                            fsm    <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                        sync_of <= (gap_cnt == GAP_LAST - 16'd1);
                    end
                end
                default: begin
                    fsm     <= IDLE;
                    state_q <= `ENUM_STATE_RESET;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state           = state_q;
    assign bus.pixelIndex      = pix_idx;
    assign bus.pixelBitIndex   = bit_idx;
    assign bus.channelIndex    = ch_idx;
    assign bus.bitPatternIndex = pat_idx;
    assign bus.streamSyncOf    = sync_of;
    assign bus.busy            = busy_q;
endmodule

// File: tb/tb_anton_neopixel_sequencer.sv
// Bench for anton_neopixel_sequencer: frame timeline model derived from the
// frame rules (192 clocks per pixel, 400-clock gap), random frame configs.
`timescale 1ns/1ps
module tb_anton_neopixel_sequencer;
    localparam int BUF_END = 12;
    localparam int BB      = 4;
    localparam int GAP     = 400;
    localparam int W       = BB + 11;
    localparam int PH_IDLE = 0;
    localparam int PH_TX   = 1;
    localparam int PH_GAP  = 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   cyc;

    anton_neopixel_sequencer_if #(.BUFFER_BITS(BB)) dut_if ();

    anton_neopixel_sequencer #(.BUFFER_END(BUF_END), .RESET_CYCLES(GAP)) dut (
        .clk7mhz  (clk),
        .syncReset(rst_n),
        .bus      (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output vector at cycle t of a given phase
    function automatic logic [W-1:0] model(input int ph, input int t, input int pstep);
        logic          st, sy, bz;
        logic [BB-1:0] px;
        logic [2:0]    bi, pa;
        logic [1:0]    ch;
        st = 0; sy = 0; bz = 0; px = '0; bi = '0; pa = '0; ch = '0;
        if (ph == PH_TX) begin
            st = 1; bz = 1;
            px = BB'((t / 192) * pstep);
            bi = 3'((t / 8) % 8);
            ch = 2'((t / 64) % 3);
            pa = 3'(t % 8);
        end else if (ph == PH_GAP) begin
            bz = 1;
            sy = (t == GAP - 1);
        end
        return {st, px, bi, ch, pa, sy, bz};
    endfunction

    function automatic int frame_len(input int pend, input bit m32);
        int eff;
        eff = (pend > BUF_END) ? BUF_END : pend;
        return m32 ? (eff / 4 + 1) * 192 : (eff + 1) * 192;
    endfunction

    task automatic cmp(input string tag, input int ph, input int t, input int pstep);
        logic [W-1:0] obs, exp_v;
        obs = {dut_if.state, dut_if.pixelIndex, dut_if.pixelBitIndex, dut_if.channelIndex,
               dut_if.bitPatternIndex, dut_if.streamSyncOf, dut_if.busy};
        exp_v = model(ph, t, pstep);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp_v);
        end
    endtask

    task automatic cmp_int(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tx_range(input string tag, input int t0, input int t1, input int pstep);
        for (int t = t0; t < t1; t++) begin
            @(negedge clk);
            cmp(tag, PH_TX, t, pstep);
        end
    endtask

    task automatic gap_range(input string tag, input int t0, input int t1, output int sync_cyc);
        sync_cyc = -1;
        for (int t = t0; t < t1; t++) begin
            @(negedge clk);
            cmp(tag, PH_GAP, t, 1);
            if (t == GAP - 1) sync_cyc = cyc;
        end
    endtask

    task automatic idle_n(input string tag, input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            cmp(tag, PH_IDLE, t, 1);
        end
    endtask

    // Drop run for one clock in IDLE, load config, then raise run
    task automatic arm(input string tag, input bit m32, input int pend, input bit lp);
        dut_if.regCtrlRun   = 1'b0;
        dut_if.regCtrl32bit = m32;
        dut_if.regPixelEnd  = BB'(pend);
        dut_if.regCtrlLoop  = lp;
        idle_n(tag, 1);
        dut_if.regCtrlRun = 1'b1;
    endtask

    initial begin
        int  sc0, sc1, len, pend;
        bit  m32;
        n_cmp = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0;
        dut_if.regCtrlRun   = 1'b1;
        dut_if.regCtrlLoop  = 1'b0;
        dut_if.regCtrl32bit = 1'b0;
        dut_if.regPixelEnd  = BB'(1);

        // 1: reset, then one 2-pixel 8-bit frame, no restart while run held
        repeat (3) @(negedge clk);
        cmp("reset", PH_IDLE, 0, 1);
        rst_n = 1'b1;
        tx_range("t1_tx", 0, 384, 1);
        gap_range("t1_gap", 0, GAP, sc0);
        idle_n("t1_idle", 20);

        // 2: 32-bit mode, end 7 -> pixels 0 and 4
        arm("t2_arm", 1'b1, 7, 1'b0);
        tx_range("t2_tx", 0, 384, 4);
        gap_range("t2_gap", 0, GAP, sc0);
        idle_n("t2_idle", 3);

        // random single-shot frames
        for (int k = 0; k < 6; k++) begin
            m32  = 1'($urandom_range(0, 1));
            pend = int'($urandom_range(0, 15));
            arm("rnd_arm", m32, pend, 1'b0);
            tx_range("rnd_tx", 0, frame_len(pend, m32), m32 ? 4 : 1);
            gap_range("rnd_gap", 0, GAP, sc0);
            idle_n("rnd_idle", 3);
        end

        // 3: looped refresh, then 4: abort at TRANSMIT clock 100
        arm("t3_arm", 1'b0, 0, 1'b1);
        tx_range("t3_tx0", 0, 192, 1);
        gap_range("t3_gap0", 0, GAP, sc0);
        tx_range("t3_tx1", 0, 192, 1);
        gap_range("t3_gap1", 0, GAP, sc1);
        cmp_int("t3_sync_period", sc1 - sc0, 192 + GAP);
        tx_range("t4_tx", 0, 100, 1);
        dut_if.regCtrlRun = 1'b0;
        gap_range("t4_gap", 0, GAP, sc0);
        idle_n("t4_idle", 5);

        // 5: reset in the middle of the gap
        m32  = 1'($urandom_range(0, 1));
        pend = int'($urandom_range(0, 15));
        arm("t5_arm", m32, pend, 1'b0);
        tx_range("t5_tx", 0, frame_len(pend, m32), m32 ? 4 : 1);
        gap_range("t5_gap", 0, 200, sc0);
        rst_n = 1'b0;
        dut_if.regCtrlRun = 1'b0;
        @(negedge clk);
        cmp("t5_rst_mid_gap", PH_IDLE, 0, 1);
        rst_n = 1'b1;
        idle_n("t5_idle", 5);

        // 6: end index beyond the buffer clamps to BUFFER_END
        arm("t6_arm8", 1'b0, 15, 1'b0);
        tx_range("t6_tx8", 0, (BUF_END + 1) * 192, 1);
        gap_range("t6_gap8", 0, GAP, sc0);
        arm("t6_arm32", 1'b1, 15, 1'b0);
        tx_range("t6_tx32", 0, (BUF_END / 4 + 1) * 192, 4);
        gap_range("t6_gap32", 0, GAP, sc0);

        // mid-frame end-index write: ignored with shadowing, live otherwise
        arm("t6_arm_cfg", 1'b0, 3, 1'b0);
        tx_range("t6_cfg_tx0", 0, 50, 1);
        dut_if.regPixelEnd = BB'(15);
`ifdef ANTON_SEQ_SHADOW_CFG_EN
        len = 4 * 192;
`else
        len = (BUF_END + 1) * 192;
`endif
        tx_range("t6_cfg_tx1", 50, len, 1);
        gap_range("t6_cfg_gap", 0, GAP, sc0);
        idle_n("t6_cfg_idle", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/anton_neopixel_sequencer.md
Name: anton_neopixel_sequencer

Overview:
Sequencer driving the combinational NeoPixel stream datapath. Generates the frame state and the nested pixel/channel/bit/pattern-slot indices that select one pattern slot per clock. Inserts the mandatory low latch gap between frames and supports single-shot or looped refresh. Sits between the control registers and the stream datapath in the top-level NeoPixel module.

Parameters:
BUFFER_END, `BUFFER_END_DEFAULT, last valid byte index of the pixel buffer
BUFFER_BITS, `CLOG2(BUFFER_END+1), width of the pixel index (localparam)
RESET_CYCLES, 400, latch-gap length in clocks (57 us at 7 MHz; must be 2..65535)

Ports:
clk7mhz  in  1  single system clock, 7 MHz
syncReset  in  1  synchronous, active-low reset
regCtrlRun  in  1  enable streaming
regCtrlLoop  in  1  1 = restart after each latch gap, 0 = single frame
regCtrl32bit  in  1  1 = 32-bit pixel mode (4 bytes/pixel), 0 = 8-bit mode
regPixelEnd  in  BUFFER_BITS  index of the last buffer byte to send
state  out  1  `ENUM_STATE_TRANSMIT or `ENUM_STATE_RESET, to datapath
pixelIndex  out  BUFFER_BITS  current buffer index
pixelBitIndex  out  3  bit within channel byte, 0..7
channelIndex  out  2  channel, 0..2 (3 never driven)
bitPatternIndex  out  3  pattern slot within a bit, 0..7
streamSyncOf  out  1  one-cycle pulse at the end of each latch gap
busy  out  1  high in TRANSMIT and GAP

Behaviour:
- Internal FSM: IDLE, TRANSMIT, GAP. State output = `ENUM_STATE_TRANSMIT only in TRANSMIT, otherwise `ENUM_STATE_RESET.
- Reset (syncReset==0 at a clock edge): FSM=IDLE; all indices 0; gap counter 0; streamSyncOf=0; busy=0. Applies mid-frame; no gap is generated.
- IDLE: regCtrlRun==1 -> TRANSMIT on the next edge, indices 0. One-cycle start latency.
- TRANSMIT, each clock: bitPatternIndex+1; on 7->0 pixelBitIndex+1; on 7->0 of that channelIndex+1; on 2->0 of that pixelIndex advances by step (1 in 8-bit mode, 4 in 32-bit mode). Lower indices reset to 0 on carry.
- Frame end: the carry out of channelIndex while pixelIndex is last -> GAP; all indices cleared to 0. In 8-bit mode, last means pixelIndex >= effEnd. In 32-bit mode, last means pixelIndex[BUFFER_BITS-1:2] >= effEnd[BUFFER_BITS-1:2], and pixelIndex[1:0] is held at 0.
- effEnd = min(regPixelEnd, BUFFER_END). The step add never wraps past BUFFER_END; the frame ends first.
- Frame length: 192 clocks per pixel. Example: 8-bit mode, regPixelEnd=2 -> 576 clocks in TRANSMIT.
- Run dropped mid-TRANSMIT (regCtrlRun==0): abort to GAP on the next edge, indices cleared, so the LEDs latch the partial data.
- GAP: 16-bit counter 0..RESET_CYCLES-1. On the last count, streamSyncOf=1 for exactly that cycle. Then: TRANSMIT if regCtrlRun && regCtrlLoop, otherwise IDLE.
- Single-shot: after the frame, stay in IDLE while regCtrlRun remains 1. A new frame needs regCtrlRun to go 0 then 1 (rising-edge detect, registered; the edge detector is cleared by reset).
- Mode or regPixelEnd changes mid-frame take effect immediately unless the optional feature is enabled.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro ANTON_SEQ_SHADOW_CFG_EN.
- Defined: regCtrl32bit, regPixelEnd and regCtrlLoop are captured into shadow registers on IDLE->TRANSMIT and GAP->TRANSMIT transitions. Mid-frame register writes do not affect the current frame.
- Undefined: live register values are used every cycle; no shadow flops.

Test Plan:
1. Reset 3 clocks, regCtrlRun=1, 8-bit mode, regPixelEnd=1, loop=0 -> TRANSMIT exactly 384 clocks, indices walk 0..7/0..7/0..2/0..1, then GAP 400 clocks, streamSyncOf pulses once, FSM goes IDLE; no restart while run stays 1.
2. 32-bit mode, regPixelEnd=7 -> pixelIndex sequence 0,4 only; 384 TRANSMIT clocks; pixelIndex[1:0] always 0.
3. loop=1, regPixelEnd=0 -> repeating 192 TRANSMIT + 400 GAP clocks; streamSyncOf period 592 clocks.
4. Drop regCtrlRun at TRANSMIT clock 100 -> GAP on the next edge, indices 0, full 400-clock gap, then IDLE.
5. syncReset low at GAP clock 200 -> next edge IDLE, all outputs 0, no streamSyncOf pulse.
6. regPixelEnd=BUFFER_END+ (all ones, where BUFFER_END < 2^BUFFER_BITS-1) -> frame ends at BUFFER_END. With ANTON_SEQ_SHADOW_CFG_EN, changing regPixelEnd mid-frame leaves the current frame length unchanged.
